cam_pwr_seq: RTL

//  Multi-channel camera power/reset sequencer; generalises the single-shot camera reset to N sensors.
//  Per channel, drives PWDN/RESETB through a timed power-up, init wait, steady-on and timed power-down,
//  all on request. Sits in the camera shell between the clock/reset block and the per-camera SCCB

---
 rtl/cam_pwr_pkg.sv | 34 +++
 rtl/cam_pwr_seq_ch.sv | 142 ++++++++++++++
 rtl/cam_pwr_seq.sv | 105 ++++++++++
 3 files changed

// File: rtl/cam_pwr_pkg.sv
// ---------------------------------------------------------------------------
// cam_pwr_pkg
// Shared types and helpers for the multi-channel camera power sequencer.
//   cam_pwr_state_t : per-channel sequencer state
//   us_to_cycles    : converts a microsecond duration into clock cycles,
//                     never returning less than one cycle
// Optional feature macro used by the files importing this package:
//   CAM_STAGGER_EN  (one channel at a time in power-up)
// ---------------------------------------------------------------------------
package cam_pwr_pkg;

    typedef enum logic [2:0] {
        OFF,
        WAIT,
        PWUP,
        RST,
        INIT,
        ON,
        DOWN
    } cam_pwr_state_t;

    // A zero-length phase would make the "leave when counter == T-1"
    // rule meaningless, so very short durations round up to one cycle.
    function automatic longint unsigned us_to_cycles(input int unsigned freq_hz,
                                                     input int unsigned us);
        longint unsigned cycles;
        cycles = 64'(freq_hz / 32'd1_000_000) * 64'(us);
        if (cycles == 64'd0) begin
            cycles = 64'd1;
        end
        return cycles;
    endfunction

endpackage

// File: rtl/cam_pwr_seq_ch.sv
// ---------------------------------------------------------------------------
// cam_pwr_seq_ch
// One camera channel: state machine plus phase counter that walks the
// sensor through power-up, reset, init wait, steady-on and power-down.
// Ports:
//   clk, rst_n      clock, synchronous active-low reset
//   start_grant_i   permission to leave OFF/WAIT for PWUP
//   pwr_req_i       level request, 1 = channel should be running
//   in_slot_o       channel is in PWUP/RST/INIT
//   down_o          channel is in DOWN
//   cam_pwdn_o      sensor PWDN, 1 = powered down
//   cam_rst_n_o     sensor RESETB, 0 = in reset
//   cam_ready_o     channel fully up
// Macro: CAM_STAGGER_EN is handled in the top; this channel simply
// parks in WAIT whenever it wants to start but has no grant.
// ---------------------------------------------------------------------------
module cam_pwr_seq_ch
    import cam_pwr_pkg::*;
#(
    parameter int              CNT_W  = 32,
    parameter longint unsigned T_PWDN = 1,
    parameter longint unsigned T_RST  = 1,
    parameter longint unsigned T_INIT = 1,
    parameter longint unsigned T_OFF  = 1
) (
    input  logic clk,
    input  logic rst_n,
    input  logic start_grant_i,
    input  logic pwr_req_i,
    output logic in_slot_o,
    output logic down_o,
    output logic cam_pwdn_o,
    output logic cam_rst_n_o,
    output logic cam_ready_o
);

    localparam logic [CNT_W-1:0] LAST_PWDN = CNT_W'(T_PWDN - 64'd1);
    localparam logic [CNT_W-1:0] LAST_RST  = CNT_W'(T_RST  - 64'd1);
    localparam logic [CNT_W-1:0] LAST_INIT = CNT_W'(T_INIT - 64'd1);
    localparam logic [CNT_W-1:0] LAST_OFF  = CNT_W'(T_OFF  - 64'd1);

    cam_pwr_state_t   state_q, state_d;
    logic [CNT_W-1:0] cnt_q, cnt_d;
    logic             timed;

    // State and phase counter registers; reset forces OFF even mid-sequence.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state_q <= OFF;
            cnt_q   <= '0;
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
        end
    end

    // Next-state logic, counter update and pin decode. Pins depend only on
    // state_q so there is no combinational path from pwr_req to the sensor.
    // DOWN ignores the request so the sensor always gets its full off time.
    always_comb begin
        state_d     = state_q;
        timed       = 1'b0;
        cam_pwdn_o  = 1'b1;
        cam_rst_n_o = 1'b0;
        cam_ready_o = 1'b0;
        in_slot_o   = 1'b0;
        down_o      = 1'b0;

        case (state_q)
            OFF: begin
                if (pwr_req_i) begin
                    state_d = start_grant_i ? PWUP : WAIT;
                end
            end
            WAIT: begin
                if (!pwr_req_i) begin
                    state_d = OFF;
                end else if (start_grant_i) begin
                    state_d = PWUP;
                end
            end
            PWUP: begin
                timed     = 1'b1;
                in_slot_o = 1'b1;
                if (!pwr_req_i) begin
                    state_d = DOWN;
                end else if (cnt_q == LAST_PWDN) begin
                    state_d = RST;
                end
            end
            RST: begin
                timed      = 1'b1;
                in_slot_o  = 1'b1;
                cam_pwdn_o = 1'b0;
                if (!pwr_req_i) begin
                    state_d = DOWN;
                end else if (cnt_q == LAST_RST) begin
                    state_d = INIT;
                end
            end
            INIT: begin
                timed       = 1'b1;
                in_slot_o   = 1'b1;
                cam_pwdn_o  = 1'b0;
                cam_rst_n_o = 1'b1;
                if (!pwr_req_i) begin
                    state_d = DOWN;
                end else if (cnt_q == LAST_INIT) begin
                    state_d = ON;
                end
            end
            ON: begin
                cam_pwdn_o  = 1'b0;
                cam_rst_n_o = 1'b1;
                cam_ready_o = 1'b1;
                if (!pwr_req_i) begin
                    state_d = DOWN;
                end
            end
            DOWN: begin
                timed  = 1'b1;
                down_o = 1'b1;
                if (cnt_q == LAST_OFF) begin
                    state_d = OFF;
                end
            end
            default: begin
                state_d = OFF;
            end
        endcase

        // Counter restarts on every state entry and only runs in timed phases.
        if (state_d != state_q) begin
            cnt_d = '0;
        end else if (timed) begin
            cnt_d = cnt_q + CNT_W'(1);
        end else begin
            cnt_d = cnt_q;
        end
    end

endmodule

// File: rtl/cam_pwr_seq.sv
// ---------------------------------------------------------------------------
// cam_pwr_seq
// Multi-channel camera power/reset sequencer. Each channel drives its
// sensor's PWDN/RESETB pins through a timed power-up and power-down and
// raises cam_ready once the sensor may be configured over SCCB.
// Ports:
//   clk        system clock
//   rst_n      synchronous active-low reset
//   pwr_req    [N_CAM] level request per channel
//   cam_pwdn   [N_CAM] sensor PWDN, 1 = powered down
//   cam_rst_n  [N_CAM] sensor RESETB, 0 = in reset
//   cam_ready  [N_CAM] channel fully up
//   busy       any channel in PWUP/RST/INIT/DOWN
// Macro: CAM_STAGGER_EN -- when defined, only one channel at a time may be
// in PWUP/RST/INIT; waiting channels start in index order.
// ---------------------------------------------------------------------------
module cam_pwr_seq
    import cam_pwr_pkg::*;
#(
    parameter int unsigned CLK_FREQ_HZ = 50_000_000,
    parameter int          N_CAM       = 1,
    parameter int unsigned PWDN_US     = 1000,
    parameter int unsigned RST_US      = 1000,
    parameter int unsigned INIT_US     = 20000,
    parameter int unsigned OFF_US      = 1000,
    parameter int          CNT_W       = 32
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic [N_CAM-1:0] pwr_req,
    output logic [N_CAM-1:0] cam_pwdn,
    output logic [N_CAM-1:0] cam_rst_n,
    output logic [N_CAM-1:0] cam_ready,
    output logic             busy
);

    localparam longint unsigned T_PWDN  = us_to_cycles(CLK_FREQ_HZ, PWDN_US);
    localparam longint unsigned T_RST   = us_to_cycles(CLK_FREQ_HZ, RST_US);
    localparam longint unsigned T_INIT  = us_to_cycles(CLK_FREQ_HZ, INIT_US);
    localparam longint unsigned T_OFF   = us_to_cycles(CLK_FREQ_HZ, OFF_US);
    localparam longint unsigned T_LIMIT = 64'd1 << CNT_W;

    // Refuse to build a sequencer whose phase counter cannot reach a phase end.
    if (T_PWDN >= T_LIMIT || T_RST >= T_LIMIT ||
        T_INIT >= T_LIMIT || T_OFF >= T_LIMIT) begin : g_cnt_w_err
        $error("cam_pwr_seq: a phase length does not fit in CNT_W bits");
    end

    if (N_CAM < 1 || N_CAM > 8) begin : g_n_cam_err
        $error("cam_pwr_seq: N_CAM must be in 1..8");
    end

    logic [N_CAM-1:0] startGrant;
    logic [N_CAM-1:0] inSlot;
    logic [N_CAM-1:0] downVec;

`ifdef CAM_STAGGER_EN
    logic [N_CAM-1:0] candidate;
    logic             found;

    // Inrush limiter: a channel sitting in OFF or WAIT with its request high
    // is a candidate; while nobody holds the power-up slot the lowest-index
    // candidate is granted. The slot is released on the edge the holder
    // reaches ON or drops to DOWN, so the next start follows a cycle later.
    always_comb begin
        startGrant = '0;
        found      = 1'b0;
        candidate  = pwr_req & ~inSlot & ~downVec & ~cam_ready;
        if (!(|inSlot)) begin
            for (int i = 0; i < N_CAM; i++) begin
                if (candidate[i] && !found) begin
                    startGrant[i] = 1'b1;
                    found         = 1'b1;
                end
            end
        end
    end
`else
    // Independent channels: every request may start immediately.
    assign startGrant = '1;
`endif

    for (genvar i = 0; i < N_CAM; i++) begin : g_ch
        cam_pwr_seq_ch #(
            .CNT_W  (CNT_W),
            .T_PWDN (T_PWDN),
            .T_RST  (T_RST),
            .T_INIT (T_INIT),
            .T_OFF  (T_OFF)
        ) u_ch (
            .clk           (clk),
            .rst_n         (rst_n),
            .start_grant_i (startGrant[i]),
            .pwr_req_i     (pwr_req[i]),
            .in_slot_o     (inSlot[i]),
            .down_o        (downVec[i]),
            .cam_pwdn_o    (cam_pwdn[i]),
            .cam_rst_n_o   (cam_rst_n[i]),
            .cam_ready_o   (cam_ready[i])
        );
    end

    assign busy = |(inSlot | downVec);

endmodule
